// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcode/funct encodings, ALU op
// codes, the decoded bundle carried through the output and skid registers,
// and small immediate-extension helpers.
package decode_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_SLT   = 4'b0111,
    ALU_SLL   = 4'b1000,
    ALU_SRL   = 4'b1001,
    ALU_NOR   = 4'b1100,
    ALU_UNDEF = 4'b1111
  } alu_op_e;

  // The immediate is held at 32 bits; every legal immediate is correctly
  // represented by sign-extending this 32-bit value to the datapath width
  // (zero-extended values always have bit 31 clear).
  typedef struct packed {
    alu_op_e     op;
    logic        ssel;
    logic [31:0] imm;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic [4:0]  rdst_id;
    logic        reg_wen;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        illegal;
  } dec_bundle_t;

  localparam int DEC_W = $bits(dec_bundle_t);

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational decoder: 32-bit instruction word -> decoded bundle.
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0]      instr_i,
  output logic [DEC_W-1:0] bundle_o
);

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;

  assign opcode = instr_i[31:26];
  assign rs     = instr_i[25:21];
  assign rt     = instr_i[20:16];
  assign rd     = instr_i[15:11];
  assign shamt  = instr_i[10:6];
  assign funct  = instr_i[5:0];
  assign imm16  = instr_i[15:0];

  dec_bundle_t b;
  logic        legal;
  logic        wen_raw;

  // Decode fields; an unsupported encoding replaces everything with the
  // canonical illegal bundle, and writes to $0 are suppressed at the end.
  always_comb begin
    b       = '0;
    b.op    = ALU_UNDEF;
    b.ssel  = 1'b1;
    legal   = 1'b0;
    wen_raw = 1'b0;

    case (opcode)
      OPC_RTYPE: begin
        b.rs1_id  = rs;
        b.rs2_id  = rt;
        b.rdst_id = rd;
        b.ssel    = 1'b1;
        wen_raw   = 1'b1;
        legal     = 1'b1;
        case (funct)
          FN_ADD:  b.op = ALU_ADD;
          FN_SUB:  b.op = ALU_SUB;
          FN_AND:  b.op = ALU_AND;
          FN_OR:   b.op = ALU_OR;
          FN_NOR:  b.op = ALU_NOR;
          FN_SLT:  b.op = ALU_SLT;
          FN_SLL, FN_SRL: begin
            // Shifts take the shifted value from rt and the amount as imm.
            b.op     = (funct == FN_SLL) ? ALU_SLL : ALU_SRL;
            b.rs1_id = rt;
            b.ssel   = 1'b0;
            b.imm    = {27'b0, shamt};
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_ADDI, OPC_SLTI, OPC_ANDI, OPC_ORI, OPC_LUI,
      OPC_LW, OPC_SW, OPC_BEQ: begin
        b.rs1_id  = rs;
        b.rs2_id  = rt;
        b.rdst_id = rt;
        b.ssel    = 1'b0;
        b.imm     = sext16(imm16);
        legal     = 1'b1;
        case (opcode)
          OPC_ADDI: begin b.op = ALU_ADD; wen_raw = 1'b1; end
          OPC_SLTI: begin b.op = ALU_SLT; wen_raw = 1'b1; end
          OPC_ANDI: begin b.op = ALU_AND; wen_raw = 1'b1; b.imm = zext16(imm16); end
          OPC_ORI:  begin b.op = ALU_OR;  wen_raw = 1'b1; b.imm = zext16(imm16); end
          OPC_LUI: begin
            b.op     = ALU_ADD;
            b.rs1_id = 5'd0;
            b.imm    = {imm16, 16'h0000};
            wen_raw  = 1'b1;
          end
          OPC_LW: begin b.op = ALU_ADD; wen_raw = 1'b1; b.mem_rd = 1'b1; end
          OPC_SW: begin b.op = ALU_ADD; b.mem_wr = 1'b1; end
          default: begin
            // beq compares rs against rt through the ALU subtractor.
            b.op     = ALU_SUB;
            b.ssel   = 1'b1;
            b.branch = 1'b1;
          end
        endcase
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      b         = '0;
      b.op      = ALU_UNDEF;
      b.ssel    = 1'b1;
      b.illegal = 1'b1;
    end else begin
      b.reg_wen = wen_raw & (b.rdst_id != 5'd0);
    end
  end

  assign bundle_o = b;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with a valid/ready handshake on both sides, a
// one-entry output register plus one skid entry, flush, and illegal flag.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. Upstream: in_ready is a register and never depends on in_valid.
// Downstream: once out_valid is high the decoded fields hold steady until
// the cycle out_ready is also high.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        op,
  output logic              ssel,
  output logic [DWIDTH-1:0] imm,
  output logic [4:0]        rs1_id,
  output logic [4:0]        rs2_id,
  output logic [4:0]        rdst_id,
  output logic              reg_wen,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              branch,
  output logic              illegal
);

  logic [DEC_W-1:0] dec_bits;
  dec_bundle_t      dec_in;

  decode_comb u_decode_comb (
    .instr_i  (instr),
    .bundle_o (dec_bits)
  );

  assign dec_in = dec_bits;

  dec_bundle_t out_q, out_d;
  dec_bundle_t skid_q, skid_d;
  logic        out_valid_q, out_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        in_ready_q, in_ready_d;

  logic accept;
  logic out_free;

  assign accept   = in_valid & in_ready_q;
  assign out_free = ~out_valid_q | out_ready;

  // Next-state: flush empties everything; otherwise a free output slot is
  // refilled from the skid entry first, then from the input, and an input
  // arriving while the output is stalled parks in the skid entry.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        // in_ready was low, so nothing can be accepted this cycle.
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec_in;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec_in;
      skid_valid_d = 1'b1;
    end

    in_ready_d = ~skid_valid_d;
  end

  // State registers; reset drops any in-flight instruction at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign op        = out_q.op;
  assign ssel      = out_q.ssel;
  assign imm       = DWIDTH'($signed(out_q.imm));
  assign rs1_id    = out_q.rs1_id;
  assign rs2_id    = out_q.rs2_id;
  assign rdst_id   = out_q.rdst_id;
  assign reg_wen   = out_q.reg_wen;
  assign mem_rd    = out_q.mem_rd;
  assign mem_wr    = out_q.mem_wr;
  assign branch    = out_q.branch;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table streamed at full rate,
// then backpressure, flush and reset corner sequences.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  op;
  logic        ssel;
  logic [31:0] imm;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic [4:0]  rdst_id;
  logic        reg_wen;
  logic        mem_rd;
  logic        mem_wr;
  logic        branch;
  logic        illegal;

  decode_stage #(.DWIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op        (op),
    .ssel      (ssel),
    .imm       (imm),
    .rs1_id    (rs1_id),
    .rs2_id    (rs2_id),
    .rdst_id   (rdst_id),
    .reg_wen   (reg_wen),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .branch    (branch),
    .illegal   (illegal)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [20:0] exp_q[$];

  // Decoded fields packed as {op, ssel, imm, rs1, rs2, rdst, wen, mrd, mwr, br, ill}.
  localparam logic [56:0] MASK_ALL = {57{1'b1}};
  localparam logic [56:0] MASK_NO_IDS = {4'hF, 1'b1, 32'hFFFF_FFFF, 15'h0, 5'h1F};

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [56:0] exp;
    logic [56:0] mask;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [56:0] pack_exp(
    input logic [3:0] e_op, input logic e_ssel, input logic [31:0] e_imm,
    input logic [4:0] e_rs1, input logic [4:0] e_rs2, input logic [4:0] e_rdst,
    input logic e_wen, input logic e_mrd, input logic e_mwr, input logic e_br,
    input logic e_ill);
    return {e_op, e_ssel, e_imm, e_rs1, e_rs2, e_rdst, e_wen, e_mrd, e_mwr, e_br, e_ill};
  endfunction

  function automatic logic [56:0] dut_fields();
    return {op, ssel, imm, rs1_id, rs2_id, rdst_id, reg_wen, mem_rd, mem_wr, branch, illegal};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic add_vec(input string name, input logic [31:0] w,
                         input logic [56:0] e, input logic [56:0] m);
    vec_t v;
    v.name = name; v.instr = w; v.exp = e; v.mask = m;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    in_valid = 1'b0;
    instr    = 32'h0;
    flush    = 1'b0;
  endtask

  task automatic drive_instr(input logic [31:0] w);
    in_valid = 1'b1;
    instr    = w;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] t4_words[4];
    int sent;
    int got_n;

    rst = 1'b1;
    drive_idle();
    out_ready = 1'b0;

    // T1: reset state
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_fields", dut_fields(), 0);

    // Decode table (op, ssel, imm, rs1, rs2, rdst, wen, mrd, mwr, br, ill)
    add_vec("addi",      32'h2008FFFF, pack_exp(4'b0010,0,32'hFFFFFFFF, 0, 8, 8,1,0,0,0,0), MASK_ALL);
    add_vec("lui",       32'h3C011234, pack_exp(4'b0010,0,32'h12340000, 0, 1, 1,1,0,0,0,0), MASK_ALL);
    add_vec("ori",       32'h34215678, pack_exp(4'b0001,0,32'h00005678, 1, 1, 1,1,0,0,0,0), MASK_ALL);
    add_vec("sll",       32'h00021080, pack_exp(4'b1000,0,32'h00000002, 2, 2, 2,1,0,0,0,0), MASK_ALL);
    add_vec("sub",       32'h01095022, pack_exp(4'b0110,1,32'h00000000, 8, 9,10,1,0,0,0,0), MASK_ALL);
    add_vec("lw",        32'h8FA9FFFC, pack_exp(4'b0010,0,32'hFFFFFFFC,29, 9, 9,1,1,0,0,0), MASK_ALL);
    add_vec("sw",        32'hAFA90008, pack_exp(4'b0010,0,32'h00000008,29, 9, 9,0,0,1,0,0), MASK_ALL);
    add_vec("beq",       32'h10228000, pack_exp(4'b0110,1,32'hFFFF8000, 1, 2, 2,0,0,0,1,0), MASK_ALL);
    add_vec("srl",       32'h00041FC2, pack_exp(4'b1001,0,32'h0000001F, 4, 4, 3,1,0,0,0,0), MASK_ALL);
    add_vec("andi",      32'h30C58001, pack_exp(4'b0000,0,32'h00008001, 6, 5, 5,1,0,0,0,0), MASK_ALL);
    add_vec("nor",       32'h00223827, pack_exp(4'b1100,1,32'h00000000, 1, 2, 7,1,0,0,0,0), MASK_ALL);
    add_vec("slti",      32'h2862FFFF, pack_exp(4'b0111,0,32'hFFFFFFFF, 3, 2, 2,1,0,0,0,0), MASK_ALL);
    add_vec("and",       32'h00221824, pack_exp(4'b0000,1,32'h00000000, 1, 2, 3,1,0,0,0,0), MASK_ALL);
    add_vec("or",        32'h00221825, pack_exp(4'b0001,1,32'h00000000, 1, 2, 3,1,0,0,0,0), MASK_ALL);
    add_vec("slt",       32'h0022182A, pack_exp(4'b0111,1,32'h00000000, 1, 2, 3,1,0,0,0,0), MASK_ALL);
    add_vec("add",       32'h00221820, pack_exp(4'b0010,1,32'h00000000, 1, 2, 3,1,0,0,0,0), MASK_ALL);
    add_vec("ill_opc",   32'hFC000000, pack_exp(4'b1111,1,32'h00000000, 0, 0, 0,0,0,0,0,1), MASK_NO_IDS);
    add_vec("ill_funct", 32'h0000003F, pack_exp(4'b1111,1,32'h00000000, 0, 0, 0,0,0,0,0,1), MASK_NO_IDS);
    add_vec("add_r0",    32'h00000020, pack_exp(4'b0010,1,32'h00000000, 0, 0, 0,0,0,0,0,0), MASK_ALL);
    add_vec("addi_r0",   32'h20000005, pack_exp(4'b0010,0,32'h00000005, 0, 0, 0,0,0,0,0,0), MASK_ALL);
    add_vec("lui_neg",   32'h3C1F8000, pack_exp(4'b0010,0,32'h80000000, 0,31,31,1,0,0,0,0), MASK_ALL);

    // T2/T3/T6: stream the table back-to-back with out_ready held high, so
    // each vector's result is checked one cycle after it is presented.
    out_ready = 1'b1;
    for (int i = 0; i <= vecs.size(); i++) begin
      if (i > 0) begin
        check({"vec_valid_", vecs[i-1].name}, out_valid, 1);
        check({"vec_fields_", vecs[i-1].name},
              dut_fields() & vecs[i-1].mask, vecs[i-1].exp & vecs[i-1].mask);
      end
      check("vec_in_ready", in_ready, 1);
      if (i < vecs.size()) drive_instr(vecs[i].instr);
      else drive_idle();
      @(negedge clk);
    end
    check("vec_drain_valid", out_valid, 0);

    // T4: backpressure with 4 distinct addi's; out_ready low for 3 cycles.
    do_reset();
    for (int k = 0; k < 4; k++)
      t4_words[k] = 32'h2000_0000 | (32'(k + 1) << 16) | (32'(k + 1) * 32'h111);
    sent  = 0;
    got_n = 0;
    for (int cyc = 0; cyc < 40 && got_n < 4; cyc++) begin
      out_ready = (cyc >= 3);
      if (sent < 4) drive_instr(t4_words[sent]);
      else drive_idle();
      if (cyc == 2) begin
        check("t4_in_ready_low", in_ready, 0);
        check("t4_sent_before_drop", 32'(sent), 2);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("t4_unexpected_output", 1, 0);
        end else begin
          check("t4_order", {rdst_id, imm[15:0]}, exp_q.pop_front());
        end
        got_n++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({t4_words[sent][20:16], t4_words[sent][15:0]});
        sent++;
      end
      @(negedge clk);
    end
    drive_idle();
    check("t4_received", 32'(got_n), 4);
    check("t4_queue_empty", 32'(exp_q.size()), 0);
    @(negedge clk);
    check("t4_no_dup", out_valid, 0);
    check("t4_in_ready_back", in_ready, 1);

    // T5: flush with output and skid both full and in_valid high.
    do_reset();
    out_ready = 1'b0;
    drive_instr(32'h2001_0001);
    @(negedge clk);
    drive_instr(32'h2002_0002);
    @(negedge clk);
    check("t5_skid_full", in_ready, 0);
    check("t5_out_full", out_valid, 1);
    drive_instr(32'h2003_0003);
    flush = 1'b1;
    @(negedge clk);
    drive_idle();
    check("t5_flush_valid", out_valid, 0);
    check("t5_flush_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t5_nothing_emitted", out_valid, 0);
    end

    // Flush while accepting into an empty stage: the instruction is dropped.
    drive_instr(32'h2004_0004);
    flush = 1'b1;
    @(negedge clk);
    drive_idle();
    check("t5_flush_drop", out_valid, 0);
    check("t5_flush_drop_ready", in_ready, 1);

    // Flush during a consume with the skid entry holding data.
    out_ready = 1'b0;
    drive_instr(32'h2005_0005);
    @(negedge clk);
    drive_instr(32'h2006_0006);
    @(negedge clk);
    drive_idle();
    out_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t5_flush_beats_skid", out_valid, 0);
    @(negedge clk);
    check("t5_skid_discarded", out_valid, 0);

    // Asynchronous reset in the middle of a stalled transfer.
    out_ready = 1'b0;
    drive_instr(32'h2007_0007);
    @(negedge clk);
    drive_instr(32'h2008_0008);
    @(negedge clk);
    drive_idle();
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_ready", in_ready, 1);
    check("rst_async_fields", dut_fields(), 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_async_nothing_left", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
